// File: rtl/alu_iter_shifter_pkg.sv
// Shared encodings for the iterative shift unit: operation codes and FSM states.
package alu_iter_shifter_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SH_SLL = 2'b00;
  localparam shift_op_t SH_SRL = 2'b01;
  localparam shift_op_t SH_ROL = 2'b10;
  localparam shift_op_t SH_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational shift/rotate by a small variable distance 0..STEP_SIZE.
// Setting STEP_SIZE = OPERAND_WIDTH-1 turns it into a full barrel shifter.
module alu_shift_step
  import alu_iter_shifter_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int SA_WIDTH      = 5,
  parameter int STEP_SIZE     = 4
) (
  input  logic [OPERAND_WIDTH-1:0] data,
  input  shift_op_t                op,
  input  logic                     fill_bit,
  input  logic [SA_WIDTH-1:0]      amt,
  output logic [OPERAND_WIDTH-1:0] result
);

  logic                       fill;
  logic [2*OPERAND_WIDTH-1:0] wide_l;
  logic [2*OPERAND_WIDTH-1:0] wide_r;
  logic [2*OPERAND_WIDTH-1:0] tmp;

  // Right shifts see a sign-extended (SRA) or zero-extended upper half.
  assign fill   = (op == SH_SRA) ? fill_bit : 1'b0;
  assign wide_l = {data, data};
  assign wide_r = {{OPERAND_WIDTH{fill}}, data};

  // Only distances up to STEP_SIZE are decoded, keeping the mux narrow.
  always_comb begin
    result = data;
    tmp    = '0;
    for (int k = 1; k <= STEP_SIZE; k++) begin
      if (amt == SA_WIDTH'(k)) begin
        case (op)
          SH_SLL: result = data << k;
          SH_ROL: begin
            tmp    = wide_l << k;
            result = tmp[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
          end
          default: begin
            tmp    = wide_r >> k;
            result = tmp[OPERAND_WIDTH-1:0];
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_iter_shifter.sv
// Iterative multi-cycle shifter (SLL/SRL/SRA/ROL) for the execute stage.
// Handshake: start_in is taken on an edge where ready_out=1 and flush_in=0; done_out pulses one cycle with result_out valid.
module alu_iter_shifter
  import alu_iter_shifter_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int SA_WIDTH      = 5,
  parameter int STEP_SIZE     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic [1:0]               op_in,
  input  logic [OPERAND_WIDTH-1:0] data_in,
  input  logic [OPERAND_WIDTH-1:0] src2_in,
  input  logic                     flush_in,
  output logic                     ready_out,
  output logic                     done_out,
  output logic [OPERAND_WIDTH-1:0] result_out,
  output logic [SA_WIDTH-1:0]      sa_out
);

  localparam logic [SA_WIDTH-1:0] STEP_MAX = SA_WIDTH'(STEP_SIZE);

  state_t                    state;
  state_t                    state_next;
  logic [OPERAND_WIDTH-1:0]  work;
  logic [OPERAND_WIDTH-1:0]  step_result;
  logic [SA_WIDTH-1:0]       rem;
  logic [SA_WIDTH-1:0]       rem_next;
  logic [SA_WIDTH-1:0]       step;
  logic [SA_WIDTH-1:0]       sa_in;
  shift_op_t                 op_q;
  logic                      sign_q;
  logic                      accept;
  logic                      src2_unused;

  assign sa_in       = src2_in[SA_WIDTH-1:0];
  assign src2_unused = ^src2_in[OPERAND_WIDTH-1:SA_WIDTH];
  assign accept      = (state == ST_IDLE) && start_in && !flush_in;
  assign step        = (rem > STEP_MAX) ? STEP_MAX : rem;
  assign rem_next    = rem - step;

  alu_shift_step #(
    .OPERAND_WIDTH (OPERAND_WIDTH),
    .SA_WIDTH      (SA_WIDTH),
    .STEP_SIZE     (STEP_SIZE)
  ) u_step (
    .data     (work),
    .op       (op_q),
    .fill_bit (sign_q),
    .amt      (step),
    .result   (step_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush_in) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_in) state_next = (sa_in == '0) ? ST_DONE : ST_SHIFT;
        ST_SHIFT: if (rem_next == '0) state_next = ST_DONE;
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_out = (state == ST_IDLE);
    done_out  = (state == ST_DONE);
  end

  // result_out loads on the edge entering DONE; a flush never touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work       <= '0;
      rem        <= '0;
      op_q       <= SH_SLL;
      sign_q     <= 1'b0;
      sa_out     <= '0;
      result_out <= '0;
    end else if (accept) begin
      work   <= data_in;
      rem    <= sa_in;
      op_q   <= op_in;
      sign_q <= data_in[OPERAND_WIDTH-1];
      sa_out <= sa_in;
      if (sa_in == '0) result_out <= data_in;
    end else if (state == ST_SHIFT && !flush_in) begin
      work <= step_result;
      rem  <= rem_next;
      if (rem_next == '0) result_out <= step_result;
    end
  end

endmodule

// File: tb/tb_alu_iter_shifter.sv
// Scenario-driven bench for alu_iter_shifter with an expected-result queue.
module tb_alu_iter_shifter;

  localparam int W    = 32;
  localparam int SAW  = 5;
  localparam int STEP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_in;
  logic [1:0]     op_in;
  logic [W-1:0]   data_in;
  logic [W-1:0]   src2_in;
  logic           flush_in;
  logic           ready_out;
  logic           done_out;
  logic [W-1:0]   result_out;
  logic [SAW-1:0] sa_out;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_iter_shifter #(.OPERAND_WIDTH(W), .SA_WIDTH(SAW), .STEP_SIZE(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .op_in      (op_in),
    .data_in    (data_in),
    .src2_in    (src2_in),
    .flush_in   (flush_in),
    .ready_out  (ready_out),
    .done_out   (done_out),
    .result_out (result_out),
    .sa_out     (sa_out)
  );

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d, input int sa);
    case (op)
      2'b00: return d << sa;
      2'b01: return d >> sa;
      2'b11: return $unsigned($signed(d) >>> sa);
      default: return (sa == 0) ? d : ((d << sa) | (d >> (W - sa)));
    endcase
  endfunction

  function automatic int latency(input int sa);
    return 1 + (sa + STEP - 1) / STEP;
  endfunction

  task automatic check_reset_values(input string name);
    checks++;
    if (ready_out !== 1'b1 || done_out !== 1'b0 || result_out !== '0 || sa_out !== '0) begin
      failures++;
      $display("FAIL %s: ready=%b done=%b result=%h sa=%0d, required 1 0 0 0",
               name, ready_out, done_out, result_out, sa_out);
    end
  endtask

  // Drives one request in an IDLE cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] d, input logic [W-1:0] s2,
                       input bit push);
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_start: got %b required 1", ready_out);
    end
    op_in = op; data_in = d; src2_in = s2; start_in = 1'b1;
    if (push) exp_q.push_back(model(op, d, int'(s2[SAW-1:0])));
    @(negedge clk);
    start_in = 1'b0;
    checks++;
    if (sa_out !== s2[SAW-1:0]) begin
      failures++;
      $display("FAIL sa_capture: got %0d required %0d", sa_out, s2[SAW-1:0]);
    end
  endtask

  // Waits (bounded) for done_out, checks latency and pops the scoreboard.
  task automatic wait_done(input int exp_lat, input string name);
    int cyc = 1;
    logic [W-1:0] exp;
    while (done_out !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done_out !== 1'b1 || cyc != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: done=%b at cycle %0d, required cycle %0d", name, done_out, cyc, exp_lat);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (result_out !== exp) begin
      failures++;
      $display("FAIL %s_result: got %h required %h", name, result_out, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b0; flush_in = 1'b0;
    op_in = 2'b00; data_in = '0; src2_in = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  task automatic test_sll();
    issue(2'b00, 32'h0000_0001, 32'hFFFF_FFE5, 1'b1);
    wait_done(3, "sll_sa5");
    checks++;
    if (result_out !== 32'h0000_0020) begin
      failures++;
      $display("FAIL sll_const: got %h required 00000020", result_out);
    end
  endtask

  task automatic test_sra_srl();
    issue(2'b11, 32'h8000_0000, 32'd31, 1'b1);
    wait_done(9, "sra_sa31");
    checks++;
    if (result_out !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sra_const: got %h required ffffffff", result_out);
    end
    issue(2'b01, 32'h8000_0000, 32'd31, 1'b1);
    wait_done(9, "srl_sa31");
    checks++;
    if (result_out !== 32'h0000_0001) begin
      failures++;
      $display("FAIL srl_const: got %h required 00000001", result_out);
    end
  endtask

  task automatic test_rol();
    issue(2'b10, 32'h8000_0001, 32'd4, 1'b1);
    wait_done(2, "rol_sa4");
    checks++;
    if (result_out !== 32'h0000_0018) begin
      failures++;
      $display("FAIL rol_const: got %h required 00000018", result_out);
    end
  endtask

  task automatic test_zero_amount();
    for (int op = 0; op < 4; op++) begin
      issue(op[1:0], 32'hDEAD_BEE0 + op, 32'hABCD_EF00 | (op << 8), 1'b1);
      wait_done(1, "sa0");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [1:0]   op = 2'($urandom_range(0, 3));
      logic [W-1:0] d  = $urandom;
      logic [W-1:0] s2 = $urandom;
      issue(op, d, s2, 1'b1);
      wait_done(latency(int'(s2[SAW-1:0])), "random");
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] held = result_out;
    logic [SAW-1:0] sa_held;
    issue(2'b01, 32'h1234_5678, 32'd20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    checks++;
    if (ready_out !== 1'b1 || done_out !== 1'b0 || result_out !== held) begin
      failures++;
      $display("FAIL flush_shift: ready=%b done=%b result=%h, required 1 0 %h",
               ready_out, done_out, result_out, held);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (done_out !== 1'b0) begin
        failures++;
        $display("FAIL flush_no_done: done=%b required 0", done_out);
      end
    end
    sa_held = sa_out;
    op_in = 2'b00; data_in = 32'h1; src2_in = 32'd3;
    start_in = 1'b1; flush_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0; flush_in = 1'b0;
    checks++;
    if (ready_out !== 1'b1 || sa_out !== sa_held) begin
      failures++;
      $display("FAIL start_flush_drop: ready=%b sa=%0d, required 1 %0d", ready_out, sa_out, sa_held);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (done_out !== 1'b0) begin
        failures++;
        $display("FAIL start_flush_done: done=%b required 0", done_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    issue(2'b11, 32'hF0F0_0F0F, 32'd31, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("reset_mid_shift");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 32'h0000_00FF, 32'd9, 1'b1);
    wait_done(latency(9), "b2b_first");
    issue(2'b10, 32'hC000_0003, 32'd2, 1'b1);
    wait_done(latency(2), "b2b_second");
    @(negedge clk);
    checks++;
    if (done_out !== 1'b0 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse_width: done=%b ready=%b required 0 1", done_out, ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_rol();
    test_zero_amount();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
